if_fetch_queue: RTL
===================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the memory controller.
- Owns the fetch PC and presents it continuously to the memory controller.
- Accepts completed instruction words (pc_done, inst, pc_num) from the controller and buffers them in a small FIFO for the IF/ID boundary.
- Handles branch redirects and drops stale returns, so decode only ever sees in-order, correct-path {pc, inst} pairs.

Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..8.
- RESET_PC, 32'h00000000, fetch PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; 0 freezes all state.
- pc_o  out  32  current fetch PC, driven to the memory controller's pc input.
- pc_done_i  in  1  controller returns an instruction this cycle.
- pc_num_i  in  32  PC of the returned instruction.
- inst_i  in  32  returned instruction word.
- branch_flag_i  in  1  redirect request from execute.
- branch_target_i  in  32  redirect target.
- stall_i  in  1  decode cannot accept this cycle.
- if_valid_o  out  1  FIFO head valid.
- if_pc_o  out  32  head PC; 0 when not valid.
- if_inst_o  out  32  head instruction; 0 when not valid.
- full_o  out  1  count == DEPTH.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc = RESET_PC; head = tail = 0; count = 0.
  - if_valid_o = 0, if_pc_o = 0, if_inst_o = 0, full_o = 0, pc_o = RESET_PC.
- rdy_in=0: no state changes; outputs hold.
- pc_o = fetch_pc, a register with no combinational path from inputs.
- pop = if_valid_o && !stall_i && !branch_flag_i.
- accept = pc_done_i && (pc_num_i == fetch_pc) && !branch_flag_i && (count < DEPTH || pop).
- On accept:
  - Write {pc_num_i, inst_i} at tail; tail wraps modulo DEPTH.
  - fetch_pc <= fetch_pc + 4, 32-bit wrapping (32'hFFFFFFFC -> 0).
- pc_done_i with pc_num_i != fetch_pc:
  - Stale return from a redirected or previously dropped fetch; discard silently; fetch_pc unchanged.
- pc_done_i while full and no pop:
  - Discard; fetch_pc unchanged. The controller refetches the same PC, normally a cache hit.
- Pop: head advances, wrapping modulo DEPTH.
- count update: +1 on accept only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous pop and return: both occur; count stays DEPTH.
- Redirect (branch_flag_i=1, highest priority):
  - Next edge: head = tail = 0, count = 0, fetch_pc <= {branch_target_i[31:2], 2'b00}.
  - Any same-cycle pc_done_i is discarded, even if pc_num_i matches.
  - No pop that cycle, regardless of stall_i.
- Redirect latency: pc_o shows the target on the cycle after branch_flag_i; the first target instruction can appear on if_valid_o no earlier than one cycle after its pc_done_i.
- Outputs:
  - if_valid_o = (count != 0); if_pc_o and if_inst_o come combinationally from the head entry, gated to 0 when not valid.
  - full_o = (count == DEPTH).
- Fill-to-visible latency: pc_done_i at edge N gives if_valid_o=1 after edge N (one cycle).
- Mid-operation reset: FIFO contents are discarded immediately. The controller's in-flight return later carries pc_num != RESET_PC unless coincident; a coincident return is accepted as correct.
- Implementation: FIFO as a register array with head/tail pointers of width $clog2(DEPTH) plus a count of width $clog2(DEPTH)+1. No latches; a single sequential process plus combinational output logic.

Test Plan:
- Reset release, pc_done_i pulses with pc_num 0,4,8 and inst 0x00000013, 0x00100093, 0x00200113, stall_i=0 -> if_pc_o 0,4,8 in order, one per cycle; pc_o steps 0->4->8->C.
- stall_i=1 with DEPTH=2, returns for PC 0,4,8 -> first two accepted, full_o=1, return for 8 dropped with pc_o held at 8; release stall -> head 0 pops, next return for 8 accepted.
- Two entries queued, branch_flag_i=1 with target 0x00000103 and a same-cycle pc_done_i for the queued PC -> if_valid_o=0 next cycle, pc_o=0x00000100, same-cycle return discarded.
- After redirect to 0x100, stale return with pc_num 0x00C -> ignored, count stays 0; return with pc_num 0x100 -> if_pc_o=0x100.
- Full FIFO with pop and matching return on the same cycle -> count stays 2; the new entry appears after the old second entry.
- fetch_pc=0xFFFFFFFC, matching return -> pc_o wraps to 0x00000000; rst asserted mid-stream -> all outputs 0 and pc_o=RESET_PC before the next clk edge.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, accepts in-order returns from
// the memory controller into a small FIFO and presents the head to decode.
// Branch redirects flush the queue and discard stale or same-cycle returns.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    output logic [31:0] pc_o,
    input  logic        pc_done_i,
    input  logic [31:0] pc_num_i,
    input  logic [31:0] inst_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   r_fetch_pc;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_inst_mem [DEPTH];

    logic          w_valid;
    logic          w_full;
    logic          w_pop;
    logic          w_accept;
    logic [31:0]   w_redirect_pc;

    // Queue status, handshake decisions and the word-aligned redirect target
    always_comb begin
        w_valid       = (r_count != '0);
        w_full        = (r_count == CW'(DEPTH));
        w_pop         = w_valid && !stall_i && !branch_flag_i;
        w_accept      = pc_done_i && (pc_num_i == r_fetch_pc) && !branch_flag_i
                        && (!w_full || w_pop);
        w_redirect_pc = branch_target_i & 32'hFFFF_FFFC;
    end

    // Fetch PC, FIFO storage, pointers and occupancy; rdy_in=0 freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
        end else if (rdy_in) begin
            if (branch_flag_i) begin
                r_fetch_pc <= w_redirect_pc;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept) begin
                    r_pc_mem[r_tail]   <= pc_num_i;
                    r_inst_mem[r_tail] <= inst_i;
                    r_tail             <= r_tail + PW'(1);
                    r_fetch_pc         <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                // Simultaneous accept and pop leave the occupancy unchanged
                case ({w_accept, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Head entry gated to zero whenever the queue is empty
    always_comb begin
        pc_o       = r_fetch_pc;
        if_valid_o = w_valid;
        full_o     = w_full;
        if_pc_o    = w_valid ? r_pc_mem[r_head]   : '0;
        if_inst_o  = w_valid ? r_inst_mem[r_head] : '0;
    end

endmodule
